// File: rtl/mc_ctrl_if.sv
// Control/status bundle between the multi-cycle controller and the datapath.
// master = controller side, slave = datapath side.
interface mc_ctrl_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite;
  logic [1:0] NPCOp;
  logic       IRWrite;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       RegWrite;
  logic       GPRSel;
  logic       WDSel;
  logic       EXTOp;
  logic       ALUSrcB;
  logic [2:0] ALUOp;
  logic       illegal;
  logic       mem_err;
  logic [3:0] state;

  modport master (
    input  Op, Funct, Zero, mem_ready,
    output PCWrite, NPCOp, IRWrite, IorD, MemRead, MemWrite, RegWrite, GPRSel, WDSel,
           EXTOp, ALUSrcB, ALUOp, illegal, mem_err, state
  );

  modport slave (
    output Op, Funct, Zero, mem_ready,
    input  PCWrite, NPCOp, IRWrite, IorD, MemRead, MemWrite, RegWrite, GPRSel, WDSel,
           EXTOp, ALUSrcB, ALUOp, illegal, mem_err, state
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the MIPS subset: sequences the shared ALU and memory port through
// fetch/decode/execute/memory/writeback, with a memory wait timeout.
module mc_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic     clk,
  input  logic     rstn,
  mc_ctrl_if.master bus_io
);

  localparam int unsigned CntW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [2:0] AluNop  = 3'b000;
  localparam logic [2:0] AluAdd  = 3'b001;
  localparam logic [2:0] AluSub  = 3'b010;
  localparam logic [2:0] AluAnd  = 3'b011;
  localparam logic [2:0] AluOr   = 3'b100;
  localparam logic [2:0] AluSlt  = 3'b101;
  localparam logic [2:0] AluSltu = 3'b110;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              illegal_q, illegal_d;
  logic              mem_err_q, mem_err_d;

  logic [2:0] alu_dec;
  logic       dec_ok;
  logic       is_rtype;
  logic       wait_st, timeout, abort;

  logic       pc_write, ir_write, iord, mem_read, mem_write, reg_write;
  logic       gpr_sel, wd_sel, ext_op, alu_src_b;
  logic [1:0] npc_op;
  logic [2:0] alu_op;

  assign is_rtype = (bus_io.Op == OpRtype);

  // Instruction decode straight off the IR; also supplies the ALU op for EXEC/ALUWB.
  always_comb begin
    alu_dec = AluNop;
    dec_ok  = 1'b1;
    case (bus_io.Op)
      OpRtype: begin
        case (bus_io.Funct)
          6'h20, 6'h21: alu_dec = AluAdd;
          6'h22, 6'h23: alu_dec = AluSub;
          6'h24:        alu_dec = AluAnd;
          6'h25:        alu_dec = AluOr;
          6'h2A:        alu_dec = AluSlt;
          6'h2B:        alu_dec = AluSltu;
          default:      dec_ok  = 1'b0;
        endcase
      end
      OpAddi:                   alu_dec = AluAdd;
      OpOri:                    alu_dec = AluOr;
      OpLw, OpSw, OpBeq, OpJ:   dec_ok  = 1'b1;
      default:                  dec_ok  = 1'b0;
    endcase
  end

  assign wait_st = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
  assign timeout = (MEM_TIMEOUT != 0) && (cnt_q == CntW'(MEM_TIMEOUT));
  // mem_ready in the timeout cycle still completes the access.
  assign abort   = wait_st && !bus_io.mem_ready && timeout;

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    illegal_d = 1'b0;
    mem_err_d = abort;
    pc_write  = 1'b0;
    npc_op    = 2'b00;
    ir_write  = 1'b0;
    iord      = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    gpr_sel   = 1'b0;
    wd_sel    = 1'b0;
    ext_op    = 1'b0;
    alu_src_b = 1'b0;
    alu_op    = AluNop;

    if (wait_st && !bus_io.mem_ready && !timeout) begin
      cnt_d = cnt_q + CntW'(1);
    end

    case (state_q)
      StFetch: begin
        mem_read = 1'b1;
        if (bus_io.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = StDecode;
        end
      end
      StDecode: begin
        if (!dec_ok) begin
          illegal_d = 1'b1;
          state_d   = StFetch;
        end else begin
          case (bus_io.Op)
            OpRtype, OpAddi, OpOri: state_d = StExec;
            OpLw, OpSw:             state_d = StMemAdr;
            OpBeq:                  state_d = StBranch;
            OpJ:                    state_d = StJump;
            default:                state_d = StFetch;
          endcase
        end
      end
      StExec: begin
        alu_src_b = !is_rtype;
        ext_op    = (bus_io.Op == OpAddi);
        alu_op    = alu_dec;
        state_d   = StAluWb;
      end
      StAluWb: begin
        reg_write = 1'b1;
        gpr_sel   = !is_rtype;
        alu_op    = alu_dec;
        state_d   = StFetch;
      end
      StMemAdr: begin
        alu_src_b = 1'b1;
        ext_op    = 1'b1;
        alu_op    = AluAdd;
        state_d   = (bus_io.Op == OpSw) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (bus_io.mem_ready) state_d = StMemWb;
        else if (abort)       state_d = StFetch;
      end
      StMemWb: begin
        reg_write = 1'b1;
        gpr_sel   = 1'b1;
        wd_sel    = 1'b1;
        state_d   = StFetch;
      end
      StMemWr: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (bus_io.mem_ready || abort) state_d = StFetch;
      end
      StBranch: begin
        alu_op   = AluSub;
        pc_write = bus_io.Zero;
        npc_op   = bus_io.Zero ? 2'b01 : 2'b00;
        state_d  = StFetch;
      end
      StJump: begin
        pc_write = 1'b1;
        npc_op   = 2'b10;
        state_d  = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StFetch;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign bus_io.PCWrite  = pc_write;
  assign bus_io.NPCOp    = npc_op;
  assign bus_io.IRWrite  = ir_write;
  assign bus_io.IorD     = iord;
  assign bus_io.MemRead  = mem_read;
  assign bus_io.MemWrite = mem_write;
  assign bus_io.RegWrite = reg_write;
  assign bus_io.GPRSel   = gpr_sel;
  assign bus_io.WDSel    = wd_sel;
  assign bus_io.EXTOp    = ext_op;
  assign bus_io.ALUSrcB  = alu_src_b;
  assign bus_io.ALUOp    = alu_op;
  assign bus_io.illegal  = illegal_q;
  assign bus_io.mem_err  = mem_err_q;
  assign bus_io.state    = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: an instruction-level model expands each instruction into its expected
// per-cycle control trace; one process compares the DUT against that trace every cycle.
module tb_mc_ctrl;

  localparam int TMO = 15;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic [1:0] npc;
    logic       irw;
    logic       iord;
    logic       mr;
    logic       mw;
    logic       rw;
    logic       gpr;
    logic       wd;
    logic       ext;
    logic       srcb;
    logic [2:0] alu;
    logic       ill;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  mc_ctrl_if bus ();

  mc_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  int   ntests = 0;
  int   nfail  = 0;
  exp_t q[$];
  exp_t want_c, got_c;
  bit   pend_ill = 1'b0;
  bit   pend_err = 1'b0;
  int   n;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    ntests++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (rstn && q.size() > 0) begin
      want_c       = q.pop_front();
      got_c.st     = bus.state;
      got_c.pcw    = bus.PCWrite;
      got_c.npc    = bus.NPCOp;
      got_c.irw    = bus.IRWrite;
      got_c.iord   = bus.IorD;
      got_c.mr     = bus.MemRead;
      got_c.mw     = bus.MemWrite;
      got_c.rw     = bus.RegWrite;
      got_c.gpr    = bus.GPRSel;
      got_c.wd     = bus.WDSel;
      got_c.ext    = bus.EXTOp;
      got_c.srcb   = bus.ALUSrcB;
      got_c.alu    = bus.ALUOp;
      got_c.ill    = bus.illegal;
      got_c.err    = bus.mem_err;
      ntests++;
      if (got_c !== want_c) begin
        nfail++;
        $display("FAIL trace t=%0t: got st=%0d ctl=%h want st=%0d ctl=%h",
                 $time, got_c.st, got_c, want_c.st, want_c);
      end
    end
  end

  // ALU op the ISA assigns to an instruction; 0 for non-ALU or unknown encodings.
  function automatic logic [2:0] alu_of(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h08) return 3'b001;
    if (op == 6'h0D) return 3'b100;
    if (op != 6'h00) return 3'b000;
    if (fn == 6'h20 || fn == 6'h21) return 3'b001;
    if (fn == 6'h22 || fn == 6'h23) return 3'b010;
    if (fn == 6'h24) return 3'b011;
    if (fn == 6'h25) return 3'b100;
    if (fn == 6'h2A) return 3'b101;
    if (fn == 6'h2B) return 3'b110;
    return 3'b000;
  endfunction

  function automatic bit legal(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) return alu_of(op, fn) != 3'b000;
    return op == 6'h08 || op == 6'h0D || op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h02;
  endfunction

  function automatic exp_t blank(input logic [3:0] st);
    exp_t e;
    e    = '0;
    e.st = st;
    return e;
  endfunction

  function automatic exp_t wait_e(input logic [3:0] st, input logic rdy);
    exp_t e;
    e = blank(st);
    if (st == 4'd0) begin
      e.mr  = 1'b1;
      e.irw = rdy;
      e.pcw = rdy;
    end else if (st == 4'd3) begin
      e.mr   = 1'b1;
      e.iord = 1'b1;
    end else begin
      e.mw   = 1'b1;
      e.iord = 1'b1;
    end
    return e;
  endfunction

  // One clock cycle: drive inputs, queue the expected outputs, advance to just after the edge.
  task automatic cyc(input logic [5:0] op, input logic [5:0] fn, input logic zero,
                     input logic rdy, input exp_t e, input bit set_ill, input bit set_err);
    e.ill = pend_ill;
    e.err = pend_err;
    q.push_back(e);
    bus.Op        = op;
    bus.Funct     = fn;
    bus.Zero      = zero;
    bus.mem_ready = rdy;
    pend_ill      = set_ill;
    pend_err      = set_err;
    @(posedge clk);
    #1;
  endtask

  // Memory-wait phase: nwait cycles of mem_ready=0, aborting once TMO wait cycles have elapsed.
  task automatic wait_phase(input logic [5:0] op, input logic [5:0] fn, input logic zero,
                            input int nwait, input logic [3:0] st, inout int ncyc,
                            output bit ok);
    ok = 1'b0;
    for (int k = 0; k <= TMO; k++) begin
      if (k >= nwait) begin
        cyc(op, fn, zero, 1'b1, wait_e(st, 1'b1), 1'b0, 1'b0);
        ncyc++;
        ok = 1'b1;
        break;
      end
      cyc(op, fn, zero, 1'b0, wait_e(st, 1'b0), 1'b0, k == TMO);
      ncyc++;
    end
  endtask

  task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic zero,
                     input int fwait, input int mwait, output int ncyc);
    exp_t e;
    bit   ok;
    ncyc = 0;
    wait_phase(op, fn, zero, fwait, 4'd0, ncyc, ok);
    if (!ok) return;
    cyc(op, fn, zero, 1'b1, blank(4'd1), !legal(op, fn), 1'b0);
    ncyc++;
    if (!legal(op, fn)) return;
    if (op == 6'h00 || op == 6'h08 || op == 6'h0D) begin
      e      = blank(4'd6);
      e.srcb = (op != 6'h00);
      e.ext  = (op == 6'h08);
      e.alu  = alu_of(op, fn);
      cyc(op, fn, zero, 1'b1, e, 1'b0, 1'b0);
      e      = blank(4'd7);
      e.rw   = 1'b1;
      e.gpr  = (op != 6'h00);
      e.alu  = alu_of(op, fn);
      cyc(op, fn, zero, 1'b1, e, 1'b0, 1'b0);
      ncyc += 2;
    end else if (op == 6'h23 || op == 6'h2B) begin
      e      = blank(4'd2);
      e.srcb = 1'b1;
      e.ext  = 1'b1;
      e.alu  = 3'b001;
      cyc(op, fn, zero, 1'b1, e, 1'b0, 1'b0);
      ncyc++;
      wait_phase(op, fn, zero, mwait, (op == 6'h23) ? 4'd3 : 4'd5, ncyc, ok);
      if (ok && op == 6'h23) begin
        e     = blank(4'd4);
        e.rw  = 1'b1;
        e.gpr = 1'b1;
        e.wd  = 1'b1;
        cyc(op, fn, zero, 1'b1, e, 1'b0, 1'b0);
        ncyc++;
      end
    end else if (op == 6'h04) begin
      e     = blank(4'd8);
      e.alu = 3'b010;
      e.pcw = zero;
      e.npc = zero ? 2'b01 : 2'b00;
      cyc(op, fn, zero, 1'b1, e, 1'b0, 1'b0);
      ncyc++;
    end else begin
      e     = blank(4'd9);
      e.pcw = 1'b1;
      e.npc = 2'b10;
      cyc(op, fn, zero, 1'b1, e, 1'b0, 1'b0);
      ncyc++;
    end
  endtask

  logic [5:0] functs [8] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h2B};

  initial begin
    rstn          = 1'b0;
    bus.Op        = '0;
    bus.Funct     = '0;
    bus.Zero      = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("reset state", 32'(bus.state), 32'd0);
    chk("reset MemRead", 32'(bus.MemRead), 32'd1);
    chk("reset illegal", 32'(bus.illegal), 32'd0);
    chk("reset mem_err", 32'(bus.mem_err), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    run(6'h00, 6'h21, 1'b0, 0, 0, n);  chk("addu cpi", 32'(n), 32'd4);
    run(6'h00, 6'h22, 1'b0, 2, 0, n);  chk("sub fetch wait 2", 32'(n), 32'd6);
    foreach (functs[i]) run(6'h00, functs[i], 1'b0, 0, 0, n);
    run(6'h08, 6'h15, 1'b0, 0, 0, n);  chk("addi cpi", 32'(n), 32'd4);
    run(6'h0D, 6'h3F, 1'b0, 0, 0, n);  chk("ori cpi", 32'(n), 32'd4);
    run(6'h23, 6'h00, 1'b0, 0, 0, n);  chk("lw cpi", 32'(n), 32'd5);
    run(6'h23, 6'h00, 1'b0, 0, 3, n);  chk("lw wait 3", 32'(n), 32'd8);
    run(6'h2B, 6'h00, 1'b0, 0, 0, n);  chk("sw cpi", 32'(n), 32'd4);
    run(6'h2B, 6'h00, 1'b0, 0, 15, n); chk("sw ready on cycle 15", 32'(n), 32'd19);
    chk("no err after late ready", 32'(bus.mem_err), 32'd0);
    run(6'h2B, 6'h00, 1'b0, 0, 20, n); chk("sw timeout cycles", 32'(n), 32'd19);
    chk("sw timeout mem_err", 32'(bus.mem_err), 32'd1);
    chk("sw timeout MemWrite", 32'(bus.MemWrite), 32'd0);
    chk("sw timeout state", 32'(bus.state), 32'd0);
    run(6'h04, 6'h00, 1'b1, 0, 0, n);  chk("beq taken cpi", 32'(n), 32'd3);
    run(6'h04, 6'h00, 1'b0, 0, 0, n);  chk("beq not taken cpi", 32'(n), 32'd3);
    run(6'h02, 6'h00, 1'b0, 0, 0, n);  chk("j cpi", 32'(n), 32'd3);
    run(6'h3F, 6'h00, 1'b0, 0, 0, n);  chk("illegal op cycles", 32'(n), 32'd2);
    chk("illegal pulse", 32'(bus.illegal), 32'd1);
    chk("illegal state", 32'(bus.state), 32'd0);
    run(6'h00, 6'h00, 1'b0, 0, 0, n);  chk("illegal funct cycles", 32'(n), 32'd2);
    run(6'h00, 6'h20, 1'b0, 20, 0, n); chk("fetch timeout cycles", 32'(n), 32'd16);
    chk("fetch timeout mem_err", 32'(bus.mem_err), 32'd1);
    run(6'h23, 6'h00, 1'b0, 0, 16, n); chk("lw timeout cycles", 32'(n), 32'd19);
    run(6'h00, 6'h25, 1'b0, 0, 0, n);  chk("or after abort", 32'(n), 32'd4);

    // Asynchronous reset while a store is waiting in MEMWR.
    cyc(6'h2B, 6'h00, 1'b0, 1'b1, wait_e(4'd0, 1'b1), 1'b0, 1'b0);
    cyc(6'h2B, 6'h00, 1'b0, 1'b1, blank(4'd1), 1'b0, 1'b0);
    want_c      = blank(4'd2);
    want_c.srcb = 1'b1;
    want_c.ext  = 1'b1;
    want_c.alu  = 3'b001;
    cyc(6'h2B, 6'h00, 1'b0, 1'b1, want_c, 1'b0, 1'b0);
    cyc(6'h2B, 6'h00, 1'b0, 1'b0, wait_e(4'd5, 1'b0), 1'b0, 1'b0);
    chk("pre-reset MEMWR", 32'(bus.state), 32'd5);
    #1 rstn = 1'b0;
    #1;
    chk("async reset state", 32'(bus.state), 32'd0);
    chk("async reset MemWrite", 32'(bus.MemWrite), 32'd0);
    chk("async reset MemRead", 32'(bus.MemRead), 32'd1);
    @(posedge clk);
    #1 rstn = 1'b1;
    run(6'h00, 6'h2A, 1'b0, 0, 0, n);  chk("slt after reset", 32'(n), 32'd4);

    #20;
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
